// File: rtl/rs_encoder_stream.sv
// Symbol-serial systematic Reed-Solomon encoder over GF(2^M).
// Data passes straight through, then NPAR parity symbols follow.
module rs_encoder_stream #(
    parameter int unsigned M    = 8,
    parameter int unsigned PRIM = 'h11D,
    parameter int unsigned K    = 64,
    parameter int unsigned NPAR = 12,
    parameter int unsigned FCR  = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [M-1:0] s_data,
    input  logic         s_last,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [M-1:0] m_data,
    output logic         m_last,
    output logic         frame_err
);

    localparam int unsigned CMAX = (K > NPAR) ? K : NPAR;
    localparam int unsigned CW   = $clog2(CMAX + 1);
    localparam logic [M-1:0] POLY = M'(PRIM);

    function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a,
                                            input logic [M-1:0] b);
        logic [M-1:0] acc;
        logic [M-1:0] t;
        acc = '0;
        t   = a;
        for (int i = 0; i < int'(M); i++) begin
            if (b[i]) acc = acc ^ t;
            t = t[M-1] ? ((t << 1) ^ POLY) : (t << 1);
        end
        return acc;
    endfunction

    // Expands prod (x + alpha^(FCR+j)); the monic top term is dropped.
    function automatic logic [NPAR*M-1:0] gen_poly();
        logic [NPAR:0][M-1:0] g;
        logic [M-1:0]         root;
        logic [NPAR*M-1:0]    r;
        g    = '0;
        g[0] = M'(1);
        root = M'(1);
        for (int j = 0; j < int'(FCR); j++) root = gf_mul(root, M'(2));
        for (int j = 0; j < int'(NPAR); j++) begin
            for (int i = int'(NPAR); i > 0; i--)
                g[i] = g[i-1] ^ gf_mul(g[i], root);
            g[0] = gf_mul(g[0], root);
            root = gf_mul(root, M'(2));
        end
        r = '0;
        for (int i = 0; i < int'(NPAR); i++) r[i*M +: M] = g[i];
        return r;
    endfunction

    localparam logic [NPAR*M-1:0] GEN = gen_poly();

    typedef enum logic {DATA, PARITY} state_t;

    state_t                  state_q, state_d;
    logic [NPAR-1:0][M-1:0]  p_q, p_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [M-1:0]            m_data_q, m_data_d;
    logic                    m_valid_q, m_valid_d;
    logic                    m_last_q, m_last_d;
    logic                    ferr_q, ferr_d;
    logic [M-1:0]            fb;
    logic                    ld;

    assign ld        = !m_valid_q || m_ready;
    assign s_ready   = (state_q == DATA) && ld;
    assign fb        = s_data ^ p_q[NPAR-1];
    assign m_valid   = m_valid_q;
    assign m_data    = m_data_q;
    assign m_last    = m_last_q;
    assign frame_err = ferr_q;

    always_comb begin
        state_d   = state_q;
        p_d       = p_q;
        cnt_d     = cnt_q;
        m_data_d  = m_data_q;
        m_valid_d = m_valid_q;
        m_last_d  = m_last_q;
        ferr_d    = 1'b0;
        if (state_q == DATA) begin
            if (s_valid && s_ready) begin
                m_data_d  = s_data;
                m_valid_d = 1'b1;
                m_last_d  = 1'b0;
                p_d[0]    = gf_mul(fb, GEN[0 +: M]);
                for (int i = 1; i < int'(NPAR); i++)
                    p_d[i] = p_q[i-1] ^ gf_mul(fb, GEN[i*M +: M]);
                ferr_d = (cnt_q == CW'(K-1)) && !s_last;
                if (s_last || cnt_q == CW'(K-1)) begin
                    state_d = PARITY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end else if (ld) begin
                m_valid_d = 1'b0;
            end
        end else if (ld) begin
            // Shifting out the register empties the LFSR for the next frame.
            m_data_d  = p_q[NPAR-1];
            m_valid_d = 1'b1;
            for (int i = int'(NPAR) - 1; i > 0; i--) p_d[i] = p_q[i-1];
            p_d[0] = '0;
            if (cnt_q == CW'(NPAR-1)) begin
                m_last_d = 1'b1;
                cnt_d    = '0;
                state_d  = DATA;
            end else begin
                m_last_d = 1'b0;
                cnt_d    = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= DATA;
            p_q       <= '0;
            cnt_q     <= '0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            p_q       <= p_d;
            cnt_q     <= cnt_d;
            m_data_q  <= m_data_d;
            m_valid_q <= m_valid_d;
            m_last_q  <= m_last_d;
            ferr_q    <= ferr_d;
        end
    end

endmodule

// File: tb/tb_rs_encoder_stream.sv
// Directed bench for rs_encoder_stream: default RS(76,64) instance
// plus a tiny NPAR=2 instance with hand-computed parity.
module tb_rs_encoder_stream;

    localparam int NPAR = 12;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       s_valid = 0, s_ready, s_last = 0;
    logic [7:0] s_data = 0;
    logic       m_valid, m_ready = 1, m_last, frame_err;
    logic [7:0] m_data;

    logic       a_valid = 0, a_ready, a_last = 0;
    logic [7:0] a_data = 0;
    logic       a_mvalid, a_mready = 1, a_mlast, a_ferr;
    logic [7:0] a_mdata;

    rs_encoder_stream u_dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_last(s_last),
        .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_last(m_last),
        .frame_err(frame_err)
    );

    rs_encoder_stream #(.K(4), .NPAR(2)) u_small (
        .clk(clk), .rst_n(rst_n),
        .s_valid(a_valid), .s_ready(a_ready),
        .s_data(a_data), .s_last(a_last),
        .m_valid(a_mvalid), .m_ready(a_mready),
        .m_data(a_mdata), .m_last(a_mlast),
        .frame_err(a_ferr)
    );

    typedef struct packed {
        logic       last;
        logic [7:0] d;
    } sym_t;

    int checks = 0;
    int errors = 0;
    int exp_tab[0:255];
    int log_tab[0:255];
    int gdesc[0:NPAR];
    sym_t in_q[$];
    logic [8:0] exp_q[$];
    logic [8:0] out_q[$];
    int ferr_cnt, stab_bad, gap_cnt, lastrdy_bad;

    function automatic int gm(int a, int b);
        if (a == 0 || b == 0) return 0;
        return exp_tab[(log_tab[a] + log_tab[b]) % 255];
    endfunction

    // Model: long division of d(x)*x^NPAR by g(x), remainder is parity.
    task automatic add_frame(input int L, input int mode, input bit mark);
        int msg[$];
        int v, c;
        sym_t s;
        for (int i = 0; i < L; i++) begin
            if (mode == 2) v = $urandom_range(255);
            else v = (mode == 1 && i == L - 1) ? 1 : 0;
            msg.push_back(v);
            s.last = mark && (i == L - 1);
            s.d = 8'(v);
            in_q.push_back(s);
            exp_q.push_back({1'b0, 8'(v)});
        end
        for (int j = 0; j < NPAR; j++) msg.push_back(0);
        for (int i = 0; i < L; i++) begin
            c = msg[i];
            if (c != 0)
                for (int j = 1; j <= NPAR; j++)
                    msg[i+j] = msg[i+j] ^ gm(gdesc[j], c);
        end
        for (int j = 0; j < NPAR; j++)
            exp_q.push_back({(j == NPAR - 1), 8'(msg[L+j])});
    endtask

    task automatic drive(input int duty, input int budget, input int limit);
        int nexp;
        int cyc;
        bit seen, hold, done;
        logic [7:0] held;
        nexp = (limit > 0) ? limit : exp_q.size();
        cyc = 0; seen = 0; hold = 0; done = 0; held = '0;
        while (!done && cyc < budget) begin
            @(negedge clk);
            s_valid = (in_q.size() > 0);
            if (in_q.size() > 0) begin
                s_data = in_q[0].d;
                s_last = in_q[0].last;
            end else begin
                s_data = '0;
                s_last = 1'b0;
            end
            m_ready = ($urandom_range(99) < duty);
            #1;
            if (hold && !(m_valid === 1'b1 && m_data === held)) stab_bad++;
            if (frame_err === 1'b1) ferr_cnt++;
            if (seen && m_valid !== 1'b1) gap_cnt++;
            if (m_valid === 1'b1) seen = 1;
            if (s_valid && s_ready === 1'b1) void'(in_q.pop_front());
            if (m_valid === 1'b1 && m_ready) begin
                out_q.push_back({m_last, m_data});
                if (m_last === 1'b1 && s_ready !== 1'b1) lastrdy_bad++;
            end
            hold = (m_valid === 1'b1) && !m_ready;
            held = m_data;
            if (out_q.size() >= nexp) done = 1;
            cyc++;
        end
        checks++;
        assert (done === 1'b1) else begin
            errors++;
            $error("FAIL drive_timeout got %0d outputs exp %0d", out_q.size(), nexp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            s_valid = 0; s_last = 0; s_data = '0; m_ready = 1;
        end
    endtask

    task automatic compare(input string tag);
        int bad;
        bad = -1;
        checks++;
        assert (out_q.size() === exp_q.size()) else begin
            errors++;
            $error("FAIL %s_len got %0d exp %0d", tag, out_q.size(), exp_q.size());
        end
        for (int i = 0; i < out_q.size() && i < exp_q.size(); i++)
            if (bad < 0 && out_q[i] !== exp_q[i]) bad = i;
        checks++;
        assert (bad === -1) else begin
            errors++;
            $error("FAIL %s_sym idx %0d got %h exp %h", tag, bad, out_q[bad], exp_q[bad]);
        end
        out_q.delete();
        exp_q.delete();
        in_q.delete();
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    initial begin
        int x;
        int g[0:NPAR];
        int bad;

        x = 1;
        for (int i = 0; i < 256; i++) begin exp_tab[i] = 0; log_tab[i] = 0; end
        for (int i = 0; i < 255; i++) begin
            exp_tab[i] = x;
            log_tab[x] = i;
            x = x << 1;
            if (x & 256) x = x ^ 'h11D;
        end
        for (int i = 0; i <= NPAR; i++) g[i] = 0;
        g[0] = 1;
        for (int j = 0; j < NPAR; j++) begin
            for (int i = NPAR; i > 0; i--) g[i] = g[i-1] ^ gm(g[i], exp_tab[j]);
            g[0] = gm(g[0], exp_tab[j]);
        end
        for (int k = 0; k <= NPAR; k++) gdesc[k] = g[NPAR-k];

        // reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_m_valid", 32'(m_valid), 0);
        chk("rst_m_data", 32'(m_data), 0);
        chk("rst_m_last", 32'(m_last), 0);
        chk("rst_frame_err", 32'(frame_err), 0);
        @(negedge clk);
        rst_n = 1;
        #1;
        chk("rst_s_ready", 32'(s_ready), 1);

        // NPAR=2 single symbol frame: 01 then parity 03, 02
        @(negedge clk);
        a_valid = 1; a_data = 8'h01; a_last = 1; a_mready = 1;
        @(negedge clk);
        a_valid = 0; a_last = 0; a_data = 0;
        #1;
        chk("small_d0", {a_mvalid, a_mlast, a_mdata}, {1'b1, 1'b0, 8'h01});
        @(negedge clk); #1;
        chk("small_p1", {a_mvalid, a_mlast, a_mdata}, {1'b1, 1'b0, 8'h03});
        @(negedge clk); #1;
        chk("small_p0", {a_mvalid, a_mlast, a_mdata}, {1'b1, 1'b1, 8'h02});
        @(negedge clk); #1;
        chk("small_idle", {a_mvalid, a_ready}, {1'b0, 1'b1});

        // all-zero full frame
        ferr_cnt = 0;
        add_frame(64, 0, 1);
        drive(100, 400, 0);
        chk("zero_ferr", 32'(ferr_cnt), 0);
        compare("zero64");
        idle(2);

        // single 1 in the lowest data position -> parity is g(x)
        add_frame(64, 1, 1);
        drive(100, 400, 0);
        bad = -1;
        if (out_q.size() < 64 + NPAR) bad = -2;
        else
            for (int j = 0; j < NPAR; j++)
                if (bad == -1 && out_q[64+j][7:0] !== 8'(gdesc[j+1])) bad = j;
        checks++;
        assert (bad === -1) else begin
            errors++;
            $error("FAIL gen_coef idx %0d got bad exp -1", bad);
        end
        compare("impulse64");
        idle(2);

        // random frames of several lengths
        add_frame(1, 2, 1);
        drive(100, 400, 0);
        compare("rand1");
        add_frame(17, 2, 1);
        drive(100, 400, 0);
        compare("rand17");
        add_frame(64, 2, 1);
        drive(100, 400, 0);
        compare("rand64");
        idle(2);

        // backpressure at 30% ready duty
        stab_bad = 0;
        add_frame(64, 1, 1);
        drive(30, 3000, 0);
        chk("bp_stable", 32'(stab_bad), 0);
        compare("bp_impulse");
        add_frame(40, 2, 1);
        drive(30, 3000, 0);
        chk("bp_stable2", 32'(stab_bad), 0);
        compare("bp_rand40");
        idle(2);

        // overlong frame: closes at K with a single frame_err pulse
        ferr_cnt = 0;
        add_frame(64, 2, 0);
        add_frame(5, 2, 1);
        drive(100, 600, 0);
        chk("ferr_pulse", 32'(ferr_cnt), 1);
        compare("overlong");
        idle(2);

        // back-to-back frames, no bubble
        gap_cnt = 0;
        lastrdy_bad = 0;
        add_frame(3, 2, 1);
        add_frame(1, 2, 1);
        add_frame(17, 2, 1);
        drive(100, 600, 0);
        chk("b2b_gap", 32'(gap_cnt), 0);
        chk("b2b_ready_at_last", 32'(lastrdy_bad), 0);
        compare("b2b");

        // reset mid-parity
        add_frame(3, 2, 1);
        drive(100, 200, 6);
        @(negedge clk);
        rst_n = 0; s_valid = 0; s_last = 0;
        @(negedge clk);
        rst_n = 1;
        #1;
        chk("midrst_m_valid", 32'(m_valid), 0);
        chk("midrst_s_ready", 32'(s_ready), 1);
        out_q.delete();
        exp_q.delete();
        in_q.delete();
        add_frame(17, 2, 1);
        drive(100, 400, 0);
        compare("after_rst");
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
